// File: rtl/chnl_tx_if.sv
// chnl_tx_if: bundles the input word stream and the Riffa CHNL TX channel of chnl_tx.
// Signals:
//   i_val / i_rdy / i_data         - TX_WIDTH-bit valid/ready input stream
//   CHNL_TX_CLK                    - channel clock forwarded by the transmitter
//   CHNL_TX / CHNL_TX_ACK          - transaction request and host acknowledge
//   CHNL_TX_LAST/LEN/OFF           - fixed transaction attributes
//   CHNL_TX_DATA / _VALID / _REN   - C_PCI_DATA_WIDTH-bit beat channel to the host
// Modports:
//   master - the transmitter (drives i_rdy and the CHNL TX outputs)
//   slave  - the environment (drives the stream and the host-side handshakes)
interface chnl_tx_if #(
  parameter int unsigned C_PCI_DATA_WIDTH = 32,
  parameter int unsigned TX_WIDTH         = 32
);
  logic                        i_val;
  logic                        i_rdy;
  logic [TX_WIDTH-1:0]         i_data;
  logic                        CHNL_TX_CLK;
  logic                        CHNL_TX;
  logic                        CHNL_TX_ACK;
  logic                        CHNL_TX_LAST;
  logic [31:0]                 CHNL_TX_LEN;
  logic [30:0]                 CHNL_TX_OFF;
  logic [C_PCI_DATA_WIDTH-1:0] CHNL_TX_DATA;
  logic                        CHNL_TX_DATA_VALID;
  logic                        CHNL_TX_DATA_REN;

  modport master (
    input  i_val, i_data, CHNL_TX_ACK, CHNL_TX_DATA_REN,
    output i_rdy, CHNL_TX_CLK, CHNL_TX, CHNL_TX_LAST, CHNL_TX_LEN, CHNL_TX_OFF,
           CHNL_TX_DATA, CHNL_TX_DATA_VALID
  );

  modport slave (
    output i_val, i_data, CHNL_TX_ACK, CHNL_TX_DATA_REN,
    input  i_rdy, CHNL_TX_CLK, CHNL_TX, CHNL_TX_LAST, CHNL_TX_LEN, CHNL_TX_OFF,
           CHNL_TX_DATA, CHNL_TX_DATA_VALID
  );
endinterface

// File: rtl/chnl_tx.sv
// chnl_tx: stream-to-Riffa CHNL transmitter.
// Repacks TX_WIDTH-bit input words into C_PCI_DATA_WIDTH-bit beats (first word in the
// least significant bits), holds them in a two-entry buffer, and sends them to the host as
// back-to-back fixed-length TX transactions of TX_LEN 32-bit words each.
// Ports:
//   clk - clock for the block and the channel (forwarded as CHNL_TX_CLK)
//   rst - synchronous active-low reset; clears the repacker, buffer and transmitter FSM
//   bus - chnl_tx_if.master: input stream plus the CHNL TX channel
module chnl_tx #(
  parameter int unsigned C_PCI_DATA_WIDTH = 32,
  parameter int unsigned TX_WIDTH         = 32,
  parameter int unsigned GCD              = 32,
  parameter int unsigned TX_LEN           = 1024
) (
  input logic       clk,
  input logic       rst,
  chnl_tx_if.master bus
);

  localparam int unsigned InSl  = TX_WIDTH / GCD;
  localparam int unsigned OutSl = C_PCI_DATA_WIDTH / GCD;
  localparam int unsigned Cap   = InSl + OutSl;
  localparam int unsigned AccW  = Cap * GCD;
  localparam int unsigned FillW = $clog2(Cap + 1);
  localparam logic [31:0] Beats = 32'(TX_LEN * 32 / C_PCI_DATA_WIDTH);

  typedef enum logic [1:0] {StIdle, StReq, StSend} state_e;

  // Repacker: GCD-wide slots, slot 0 at the LSB; slots at or above fill_q are always zero.
  logic [AccW-1:0]  acc_q, acc_d, acc_shift;
  logic [FillW-1:0] fill_q, fill_d, fill_base;
  logic             rp_push, rp_pop, rp_vld;

  // Two-entry buffer; bf0 is the head.
  logic [C_PCI_DATA_WIDTH-1:0] bf0_q, bf0_d, bf1_q, bf1_d;
  logic [1:0]                  bf_cnt_q, bf_cnt_d;
  logic                        bf_vld, bf_in_rdy, bf_rdy, bf_pop;

  state_e      state_q, state_d;
  logic [31:0] cnt_left_q, cnt_left_d;

  // Input ready depends only on the fill level, so a full input word always fits.
  assign bus.i_rdy = (fill_q <= FillW'(OutSl));
  assign rp_push   = bus.i_val && bus.i_rdy;
  assign rp_vld    = (fill_q >= FillW'(OutSl));
  assign rp_pop    = rp_vld && bf_in_rdy;

  always_comb begin
    acc_shift = rp_pop ? (acc_q >> C_PCI_DATA_WIDTH) : acc_q;
    fill_base = rp_pop ? (fill_q - FillW'(OutSl)) : fill_q;
    acc_d     = acc_shift;
    fill_d    = fill_base;
    if (rp_push) begin
      acc_d  = acc_shift | (AccW'(bus.i_data) << (32'(fill_base) * GCD));
      fill_d = fill_base + FillW'(InSl);
    end
  end

  assign bf_vld    = (bf_cnt_q != 2'd0);
  assign bf_in_rdy = (bf_cnt_q != 2'd2);
  assign bf_pop    = bf_vld && bf_rdy;

  always_comb begin
    bf0_d    = bf0_q;
    bf1_d    = bf1_q;
    bf_cnt_d = bf_cnt_q;
    if (bf_pop) begin
      bf0_d = bf1_q;
    end
    if (rp_pop) begin
      // Write into the first slot that is free after this cycle's pop.
      if (bf_cnt_q == 2'd0 || (bf_cnt_q == 2'd1 && bf_pop)) begin
        bf0_d = acc_q[C_PCI_DATA_WIDTH-1:0];
      end else begin
        bf1_d = acc_q[C_PCI_DATA_WIDTH-1:0];
      end
    end
    case ({rp_pop, bf_pop})
      2'b10:   bf_cnt_d = bf_cnt_q + 2'd1;
      2'b01:   bf_cnt_d = bf_cnt_q - 2'd1;
      default: bf_cnt_d = bf_cnt_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_left_d = cnt_left_q;
    bf_rdy     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bf_vld) begin
          state_d    = StReq;
          cnt_left_d = Beats;
        end
      end
      StReq: begin
        if (bus.CHNL_TX_ACK) begin
          state_d = StSend;
        end
      end
      StSend: begin
        bf_rdy = bus.CHNL_TX_DATA_REN;
        if (bf_vld && bus.CHNL_TX_DATA_REN) begin
          cnt_left_d = cnt_left_q - 32'd1;
          if (cnt_left_q == 32'd1) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q      <= '0;
      fill_q     <= '0;
      bf0_q      <= '0;
      bf1_q      <= '0;
      bf_cnt_q   <= '0;
      state_q    <= StIdle;
      cnt_left_q <= '0;
    end else begin
      acc_q      <= acc_d;
      fill_q     <= fill_d;
      bf0_q      <= bf0_d;
      bf1_q      <= bf1_d;
      bf_cnt_q   <= bf_cnt_d;
      state_q    <= state_d;
      cnt_left_q <= cnt_left_d;
    end
  end

  assign bus.CHNL_TX_CLK        = clk;
  assign bus.CHNL_TX_LAST       = 1'b1;
  assign bus.CHNL_TX_LEN        = 32'(TX_LEN);
  assign bus.CHNL_TX_OFF        = '0;
  assign bus.CHNL_TX_DATA       = bf0_q;
  assign bus.CHNL_TX            = (state_q != StIdle);
  assign bus.CHNL_TX_DATA_VALID = (state_q == StSend) && bf_vld;

endmodule

// File: tb/tb_chnl_tx.sv
module tb_chnl_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_x;
  int checks = 0;
  int errors = 0;

  // a: 32/32 TX_LEN=4, b: 64/32 TX_LEN=4, c: 64/32 TX_LEN=2, d: 32/32 TX_LEN=8
  chnl_tx_if #(.C_PCI_DATA_WIDTH(32), .TX_WIDTH(32)) if_a ();
  chnl_tx_if #(.C_PCI_DATA_WIDTH(64), .TX_WIDTH(32)) if_b ();
  chnl_tx_if #(.C_PCI_DATA_WIDTH(64), .TX_WIDTH(32)) if_c ();
  chnl_tx_if #(.C_PCI_DATA_WIDTH(32), .TX_WIDTH(32)) if_d ();

  chnl_tx #(.C_PCI_DATA_WIDTH(32), .TX_WIDTH(32), .GCD(32), .TX_LEN(4)) u_a (
    .clk(clk), .rst(rst_a), .bus(if_a));
  chnl_tx #(.C_PCI_DATA_WIDTH(64), .TX_WIDTH(32), .GCD(32), .TX_LEN(4)) u_b (
    .clk(clk), .rst(rst_x), .bus(if_b));
  chnl_tx #(.C_PCI_DATA_WIDTH(64), .TX_WIDTH(32), .GCD(32), .TX_LEN(2)) u_c (
    .clk(clk), .rst(rst_x), .bus(if_c));
  chnl_tx #(.C_PCI_DATA_WIDTH(32), .TX_WIDTH(32), .GCD(32), .TX_LEN(8)) u_d (
    .clk(clk), .rst(rst_x), .bus(if_d));

  // Accepted beats and count of CHNL_TX rising edges per instance.
  logic [31:0] q_a[$];
  logic [63:0] q_b[$];
  logic [63:0] q_c[$];
  logic [31:0] q_d[$];
  int ntx_a = 0, ntx_b = 0, ntx_c = 0, ntx_d = 0;
  logic txp_a = 1'b0, txp_b = 1'b0, txp_c = 1'b0, txp_d = 1'b0;

  always @(negedge clk) begin
    if (if_a.CHNL_TX_DATA_VALID && if_a.CHNL_TX_DATA_REN) q_a.push_back(if_a.CHNL_TX_DATA);
    if (if_b.CHNL_TX_DATA_VALID && if_b.CHNL_TX_DATA_REN) q_b.push_back(if_b.CHNL_TX_DATA);
    if (if_c.CHNL_TX_DATA_VALID && if_c.CHNL_TX_DATA_REN) q_c.push_back(if_c.CHNL_TX_DATA);
    if (if_d.CHNL_TX_DATA_VALID && if_d.CHNL_TX_DATA_REN) q_d.push_back(if_d.CHNL_TX_DATA);
    if (if_a.CHNL_TX && !txp_a) ntx_a <= ntx_a + 1;
    if (if_b.CHNL_TX && !txp_b) ntx_b <= ntx_b + 1;
    if (if_c.CHNL_TX && !txp_c) ntx_c <= ntx_c + 1;
    if (if_d.CHNL_TX && !txp_d) ntx_d <= ntx_d + 1;
    txp_a <= if_a.CHNL_TX;
    txp_b <= if_b.CHNL_TX;
    txp_c <= if_c.CHNL_TX;
    txp_d <= if_d.CHNL_TX;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic        val;
    logic [31:0] data;
    logic        ack;
    logic        ren;
    logic        exp_rdy;
    logic        exp_tx;
    logic        exp_vld;
    logic [31:0] exp_data;
  } vec_t;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [10];
    int   n;
    int   tx0;

    tbl[0] = '{1'b1, 32'h11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[1] = '{1'b1, 32'h22, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[2] = '{1'b1, 32'h33, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[3] = '{1'b1, 32'h44, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0};
    tbl[4] = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h11};
    tbl[5] = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h22};
    tbl[6] = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h33};
    tbl[7] = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h44};
    tbl[8] = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[9] = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};

    rst_a = 1'b0;
    rst_x = 1'b0;
    if_a.i_val = 1'b0; if_a.i_data = '0; if_a.CHNL_TX_ACK = 1'b0; if_a.CHNL_TX_DATA_REN = 1'b0;
    if_b.i_val = 1'b0; if_b.i_data = '0; if_b.CHNL_TX_ACK = 1'b1; if_b.CHNL_TX_DATA_REN = 1'b1;
    if_c.i_val = 1'b0; if_c.i_data = '0; if_c.CHNL_TX_ACK = 1'b1; if_c.CHNL_TX_DATA_REN = 1'b1;
    if_d.i_val = 1'b0; if_d.i_data = '0; if_d.CHNL_TX_ACK = 1'b1; if_d.CHNL_TX_DATA_REN = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reset state.
    @(negedge clk);
    chk("reset_tx_a", 64'(if_a.CHNL_TX), 64'd0);
    chk("reset_vld_a", 64'(if_a.CHNL_TX_DATA_VALID), 64'd0);
    chk("reset_irdy_a", 64'(if_a.i_rdy), 64'd1);
    chk("reset_tx_b", 64'(if_b.CHNL_TX), 64'd0);
    chk("reset_irdy_b", 64'(if_b.i_rdy), 64'd1);
    @(posedge clk);
    #1;
    chk("clk_fwd_high", 64'(if_a.CHNL_TX_CLK), 64'd1);
    rst_a = 1'b1;
    rst_x = 1'b1;

    // Single transaction, cycle-exact.
    for (int i = 0; i < 10; i++) begin
      if_a.i_val            = tbl[i].val;
      if_a.i_data           = tbl[i].data;
      if_a.CHNL_TX_ACK      = tbl[i].ack;
      if_a.CHNL_TX_DATA_REN = tbl[i].ren;
      @(negedge clk);
      chk($sformatf("t1_irdy[%0d]", i), 64'(if_a.i_rdy), 64'(tbl[i].exp_rdy));
      chk($sformatf("t1_tx[%0d]", i), 64'(if_a.CHNL_TX), 64'(tbl[i].exp_tx));
      chk($sformatf("t1_vld[%0d]", i), 64'(if_a.CHNL_TX_DATA_VALID), 64'(tbl[i].exp_vld));
      if (tbl[i].exp_vld) begin
        chk($sformatf("t1_data[%0d]", i), 64'(if_a.CHNL_TX_DATA), 64'(tbl[i].exp_data));
      end
      if (tbl[i].exp_tx) begin
        chk($sformatf("t1_len[%0d]", i), 64'(if_a.CHNL_TX_LEN), 64'd4);
        chk($sformatf("t1_last[%0d]", i), 64'(if_a.CHNL_TX_LAST), 64'd1);
        chk($sformatf("t1_off[%0d]", i), 64'(if_a.CHNL_TX_OFF), 64'd0);
        chk($sformatf("t1_clk[%0d]", i), 64'(if_a.CHNL_TX_CLK), 64'd0);
      end
      @(posedge clk);
      #1;
    end
    if_a.i_val = 1'b0;

    // Width repacking: 32-bit words into 64-bit beats.
    begin : push_b
      int idx, p;
      idx = 0; p = 0;
      while (idx < 4 && p < 50) begin
        if_b.i_val  = 1'b1;
        if_b.i_data = 32'hA + 32'(idx);
        @(negedge clk);
        if (if_b.i_rdy) idx++;
        @(posedge clk);
        #1;
        p++;
      end
      if_b.i_val = 1'b0;
      chk("rp_push_done", 64'(idx), 64'd4);
    end
    n = 0;
    while ((q_b.size() < 2 || if_b.CHNL_TX) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("rp_in_time", 64'(n < 100), 64'd1);
    chk("rp_nbeats", 64'(q_b.size()), 64'd2);
    if (q_b.size() >= 2) begin
      chk("rp_beat0", q_b[0], 64'h0000000B_0000000A);
      chk("rp_beat1", q_b[1], 64'h0000000D_0000000C);
    end
    chk("rp_ntx", 64'(ntx_b), 64'd1);

    // Back-to-back: 5 words, TX_LEN=2 on a 64-bit channel.
    begin : push_c
      int idx, p;
      idx = 0; p = 0;
      while (idx < 5 && p < 50) begin
        if_c.i_val  = 1'b1;
        if_c.i_data = 32'h1 + 32'(idx);
        @(negedge clk);
        if (if_c.i_rdy) idx++;
        @(posedge clk);
        #1;
        p++;
      end
      if_c.i_val = 1'b0;
      chk("b2b_push_done", 64'(idx), 64'd5);
    end
    n = 0;
    while ((q_c.size() < 2 || if_c.CHNL_TX) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("b2b_in_time", 64'(n < 100), 64'd1);
    repeat (10) @(posedge clk);
    #1;
    chk("b2b_nbeats", 64'(q_c.size()), 64'd2);
    if (q_c.size() >= 2) begin
      chk("b2b_beat0", q_c[0], 64'h00000002_00000001);
      chk("b2b_beat1", q_c[1], 64'h00000004_00000003);
    end
    chk("b2b_ntx", 64'(ntx_c), 64'd2);
    @(negedge clk);
    chk("b2b_held_tx", 64'(if_c.CHNL_TX), 64'd0);
    @(posedge clk);
    #1;
    begin : push_c6
      int p;
      p = 0;
      if_c.i_val  = 1'b1;
      if_c.i_data = 32'h6;
      @(negedge clk);
      while (!if_c.i_rdy && p < 20) begin
        @(negedge clk);
        p++;
      end
      @(posedge clk);
      #1;
      if_c.i_val = 1'b0;
    end
    n = 0;
    while ((q_c.size() < 3 || if_c.CHNL_TX) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("b2b_third_in_time", 64'(n < 100), 64'd1);
    chk("b2b_nbeats3", 64'(q_c.size()), 64'd3);
    if (q_c.size() >= 3) chk("b2b_beat2", q_c[2], 64'h00000006_00000005);
    chk("b2b_ntx3", 64'(ntx_c), 64'd3);

    // Input stall: 3 words, 10 idle cycles, 5 words, TX_LEN=8.
    for (int ph = 0; ph < 2; ph++) begin
      int idx, p, lo, hi;
      lo = (ph == 0) ? 0 : 3;
      hi = (ph == 0) ? 3 : 8;
      idx = lo; p = 0;
      while (idx < hi && p < 50) begin
        if_d.i_val  = 1'b1;
        if_d.i_data = 32'hD0 + 32'(idx);
        @(negedge clk);
        if (if_d.i_rdy) idx++;
        @(posedge clk);
        #1;
        p++;
      end
      if_d.i_val = 1'b0;
      chk($sformatf("stall_push_done[%0d]", ph), 64'(idx), 64'(hi));
      if (ph == 0) begin
        repeat (10) @(posedge clk);
        #1;
        chk("stall_nbeats_mid", 64'(q_d.size()), 64'd3);
        @(negedge clk);
        chk("stall_tx_mid", 64'(if_d.CHNL_TX), 64'd1);
        chk("stall_vld_mid", 64'(if_d.CHNL_TX_DATA_VALID), 64'd0);
        @(posedge clk);
        #1;
      end
    end
    n = 0;
    while ((q_d.size() < 8 || if_d.CHNL_TX) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("stall_in_time", 64'(n < 100), 64'd1);
    chk("stall_nbeats", 64'(q_d.size()), 64'd8);
    for (int i = 0; i < q_d.size() && i < 8; i++) begin
      chk($sformatf("stall_beat[%0d]", i), 64'(q_d[i]), 64'(32'hD0 + 32'(i)));
    end
    chk("stall_ntx", 64'(ntx_d), 64'd1);

    // Backpressure on instance a: ACK held off 3 cycles, REN toggling.
    q_a.delete();
    tx0 = ntx_a;
    if_a.CHNL_TX_ACK = 1'b0;
    fork
      begin : bp_push
        int idx, p;
        idx = 0; p = 0;
        while (idx < 4 && p < 50) begin
          if_a.i_val  = 1'b1;
          if_a.i_data = 32'h51 + 32'(idx);
          @(negedge clk);
          if (if_a.i_rdy) idx++;
          @(posedge clk);
          #1;
          p++;
        end
        if_a.i_val = 1'b0;
        chk("bp_push_done", 64'(idx), 64'd4);
      end
      begin : bp_ack
        int m;
        m = 0;
        while (!if_a.CHNL_TX && m < 50) begin
          @(posedge clk);
          #1;
          m++;
        end
        chk("bp_req_in_time", 64'(m < 50), 64'd1);
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk($sformatf("bp_vld_pre_ack[%0d]", k), 64'(if_a.CHNL_TX_DATA_VALID), 64'd0);
          if (k == 2) chk("bp_irdy_full", 64'(if_a.i_rdy), 64'd0);
          @(posedge clk);
          #1;
        end
        if_a.CHNL_TX_ACK = 1'b1;
      end
      begin : bp_ren
        for (int k = 0; k < 30; k++) begin
          if_a.CHNL_TX_DATA_REN = (k % 2 == 0);
          @(posedge clk);
          #1;
        end
        if_a.CHNL_TX_DATA_REN = 1'b1;
      end
    join
    n = 0;
    while ((q_a.size() < 4 || if_a.CHNL_TX) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (5) @(posedge clk);
    #1;
    chk("bp_in_time", 64'(n < 100), 64'd1);
    chk("bp_nbeats", 64'(q_a.size()), 64'd4);
    for (int i = 0; i < q_a.size() && i < 4; i++) begin
      chk($sformatf("bp_beat[%0d]", i), 64'(q_a[i]), 64'(32'h51 + 32'(i)));
    end
    chk("bp_ntx", 64'(ntx_a - tx0), 64'd1);

    // Reset mid-transaction after 2 of 4 beats.
    q_a.delete();
    begin : rst_push
      int idx, p;
      idx = 0; p = 0;
      while (idx < 4 && p < 50) begin
        if_a.i_val  = 1'b1;
        if_a.i_data = 32'h61 + 32'(idx);
        @(negedge clk);
        if (if_a.i_rdy) idx++;
        @(posedge clk);
        #1;
        p++;
      end
      if_a.i_val = 1'b0;
    end
    n = 0;
    while (q_a.size() < 2 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("rst_two_beats_in_time", 64'(n < 50), 64'd1);
    rst_a = 1'b0;
    if_a.CHNL_TX_DATA_REN = 1'b0;
    @(posedge clk);
    #1;
    rst_a = 1'b1;
    @(negedge clk);
    chk("rst_tx_after", 64'(if_a.CHNL_TX), 64'd0);
    chk("rst_vld_after", 64'(if_a.CHNL_TX_DATA_VALID), 64'd0);
    chk("rst_irdy_after", 64'(if_a.i_rdy), 64'd1);
    @(posedge clk);
    #1;
    chk("rst_beats_before", 64'(q_a.size()), 64'd2);
    q_a.delete();
    tx0 = ntx_a;
    if_a.CHNL_TX_DATA_REN = 1'b1;
    begin : rst_push2
      int idx, p;
      idx = 0; p = 0;
      while (idx < 4 && p < 50) begin
        if_a.i_val  = 1'b1;
        if_a.i_data = 32'h71 + 32'(idx);
        @(negedge clk);
        if (if_a.i_rdy) idx++;
        @(posedge clk);
        #1;
        p++;
      end
      if_a.i_val = 1'b0;
    end
    n = 0;
    while ((q_a.size() < 4 || if_a.CHNL_TX) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (5) @(posedge clk);
    #1;
    chk("rst_new_in_time", 64'(n < 100), 64'd1);
    chk("rst_new_nbeats", 64'(q_a.size()), 64'd4);
    for (int i = 0; i < q_a.size() && i < 4; i++) begin
      chk($sformatf("rst_new_beat[%0d]", i), 64'(q_a[i]), 64'(32'h71 + 32'(i)));
    end
    chk("rst_new_ntx", 64'(ntx_a - tx0), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
